// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM states, command layout and constants shared by alu_seq and its bench.
package alu_seq_pkg;

    localparam int CMD_DATA_W = 8;
    localparam int CMD_TAG_W  = 4;

    // Result the ALU reports for a divide by zero; the sequencer never decides on it.
    localparam logic [2*CMD_DATA_W-1:0] ERROR_CODE = 16'hDEAD;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_DIV = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CAPT,
        RESP
    } state_e;

    typedef struct packed {
        logic [2:0]            oper;
        logic [CMD_DATA_W-1:0] a;
        logic [CMD_DATA_W-1:0] b;
        logic [CMD_TAG_W-1:0]  tag;
    } cmd_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'(OP_DIV);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous FIFO with pointer-wrap bit for full/empty.
// Ports: clk, reset (sync, active-high), push/wdata (write, ignored when full),
//        pop/rdata (head, advanced when not empty), full, empty.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full)
                wptr <= wptr + 1'b1;
            if (pop && !empty)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: buffers ALU commands, issues each as a one-cycle execute pulse and returns the result.
// Ports: clk, reset (sync, active-high);
//        cmd_valid/cmd_ready/cmd_oper/cmd_a/cmd_b/cmd_tag  command stream in;
//        alu_execute/alu_oper/alu_a/alu_b/alu_res          ALU issue and registered result;
//        rsp_valid/rsp_ready/rsp_data/rsp_tag/rsp_err      response stream out;
//        ops_done/err_count                                 statistics.
// Build option: define ALU_SEQ_STATS_EN to enable the saturating statistics counters;
// otherwise ops_done and err_count are tied to zero.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_WIDTH = CMD_DATA_W,
    parameter int TAG_WIDTH  = CMD_TAG_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_oper,
    input  logic [DATA_WIDTH-1:0]   cmd_a,
    input  logic [DATA_WIDTH-1:0]   cmd_b,
    input  logic [TAG_WIDTH-1:0]    cmd_tag,
    output logic                    alu_execute,
    output logic [2:0]              alu_oper,
    output logic [DATA_WIDTH-1:0]   alu_a,
    output logic [DATA_WIDTH-1:0]   alu_b,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_data,
    output logic [TAG_WIDTH-1:0]    rsp_tag,
    output logic                    rsp_err,
    output logic [15:0]             ops_done,
    output logic [15:0]             err_count
);

    cmd_t   wcmd;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   bypass;
    state_e state;
    state_e state_nx;

    assign wcmd        = '{oper: cmd_oper, a: cmd_a, b: cmd_b, tag: cmd_tag};
    assign cmd_ready   = !fifo_full;
    assign alu_execute = state == EXEC;
    assign rsp_valid   = state == RESP;

    alu_cmd_fifo #(
        .WIDTH($bits(cmd_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (cmd_valid && cmd_ready),
        .wdata(wcmd),
        .pop  (pop),
        .rdata(head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    // Illegal opcodes skip EXEC but still pass through CAPT, so they answer
    // one cycle sooner than a legal command and never pulse the ALU.
    always_comb begin
        pop      = 1'b0;
        state_nx = state;
        case (state)
            IDLE: if (!fifo_empty) begin
                pop      = 1'b1;
                state_nx = op_legal(head.oper) ? EXEC : CAPT;
            end
            EXEC:    state_nx = CAPT;
            CAPT:    state_nx = RESP;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bypass   <= 1'b0;
            alu_oper <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (pop) begin
                rsp_tag <= head.tag;
                bypass  <= !op_legal(head.oper);
                // ALU operands only change when a command is actually issued.
                if (op_legal(head.oper)) begin
                    alu_oper <= head.oper;
                    alu_a    <= head.a;
                    alu_b    <= head.b;
                end
            end
            if (state == CAPT) begin
                rsp_data <= bypass ? '0 : alu_res;
                rsp_err  <= bypass || (alu_oper == OP_DIV && alu_b == '0);
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_fire;

    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            ops_done  <= '0;
            err_count <= '0;
        end else if (rsp_fire) begin
            ops_done  <= (ops_done == 16'hFFFF) ? ops_done : ops_done + 16'd1;
            err_count <= (!rsp_err || err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
        end
    end
`else
    assign ops_done  = '0;
    assign err_count = '0;
`endif

endmodule
